// File: rtl/clock_div_pkg.sv
// Shared definitions for the clock divider family.
// Holds the checker FSM state encoding and the default sizing constants
// used by clock_div_checker and anything that talks to it.
package clock_div_pkg;

  localparam int PERIOD_W_DEF   = 8;
  localparam int LOCK_COUNT_DEF = 4;
  localparam int ERR_W_DEF      = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACQ  = 2'd1,
    S_LOCK = 2'd2
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk     - destination clock
//   reset_n - async active-low reset, flops clear to 0
//   d_i     - asynchronous input
//   q_o     - synchronized output (second flop)
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/clock_div_checker.sv
// Receiving-end checker for a divided clock.
// Synchronizes clk_in, detects its edges, measures the rise-to-rise period in
// clk cycles and tracks lock against exp_period.
// Ports:
//   clk, reset_n  - reference clock, async active-low reset
//   clk_in        - divided clock under test (async to clk)
//   exp_period    - expected period in clk cycles, compared live
//   clr_err       - synchronous clear of err_cnt (wins over a coincident err)
//   rise_pulse    - one-cycle pulse per detected clk_in rising edge
//   fall_pulse    - one-cycle pulse per detected clk_in falling edge
//   period        - last measured period, held between measurements
//   period_valid  - one-cycle strobe when period updates
//   locked        - high while in LOCK
//   err           - one-cycle pulse on mismatch-while-locked or timeout
//   err_cnt       - saturating count of err pulses
module clock_div_checker
  import clock_div_pkg::*;
#(
  parameter int PERIOD_W   = PERIOD_W_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int ERR_W      = ERR_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clk_in,
  input  logic [PERIOD_W-1:0] exp_period,
  input  logic                clr_err,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                locked,
  output logic                err,
  output logic [ERR_W-1:0]    err_cnt
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  logic                s2;
  logic                s3_q;
  logic                rise, fall;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                cnt_max;
  logic [PERIOD_W-1:0] meas;
  logic                match;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                pv_q, pv_d;
  logic                err_q, err_d;
  logic                locked_q;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic [3:0]          match_cnt_q, match_cnt_d;
  state_e              state_q, state_d;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (clk_in),
    .q_o     (s2)
  );

  // s3 is the edge-detect history flop behind the synchronizer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s3_q <= 1'b0;
    else          s3_q <= s2;
  end

  assign rise = s2 & ~s3_q;
  assign fall = ~s2 & s3_q;

  // meas counts the rise cycle itself, so a P-cycle clk_in gives meas = P
  assign cnt_max = (cnt_q == '1);
  assign meas    = cnt_max ? cnt_q : cnt_q + 1'b1;
  assign match   = (meas == exp_period);

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    period_d    = period_q;
    pv_d        = 1'b0;
    err_d       = 1'b0;
    cnt_d       = rise ? '0 : (cnt_max ? cnt_q : cnt_q + 1'b1);

    // a rise on the same cycle as a timeout is taken as a normal rise
    if (rise) begin
      case (state_q)
        S_IDLE: begin
          // first rise only arms the measurement
          state_d     = S_ACQ;
          match_cnt_d = '0;
        end
        S_ACQ: begin
          period_d = meas;
          pv_d     = 1'b1;
          if (match) begin
            match_cnt_d = match_cnt_q + 1'b1;
            if (match_cnt_q + 1'b1 == LOCK_N) state_d = S_LOCK;
          end else begin
            match_cnt_d = '0;
          end
        end
        S_LOCK: begin
          period_d = meas;
          pv_d     = 1'b1;
          if (!match) begin
            err_d       = 1'b1;
            state_d     = S_ACQ;
            match_cnt_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (cnt_max && state_q != S_IDLE) begin
      // loss of clock: report once, then sit in IDLE while cnt stays saturated
      err_d   = 1'b1;
      state_d = S_IDLE;
    end

    err_cnt_d = err_cnt_q;
    if (clr_err)                         err_cnt_d = '0;
    else if (err_q && err_cnt_q != '1)   err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      pv_q        <= 1'b0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
      err_cnt_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      pv_q        <= pv_d;
      err_q       <= err_d;
      locked_q    <= (state_d == S_LOCK);
      err_cnt_q   <= err_cnt_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign rise_pulse   = rise;
  assign fall_pulse   = fall;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign err          = err_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_clock_div_checker.sv
module tb_clock_div_checker;

  localparam int PW     = 8;
  localparam int LC     = 4;
  localparam int EW     = 8;
  localparam int CMAX   = (1 << PW) - 1;
  localparam int EMAX   = (1 << EW) - 1;
  localparam int M_IDLE = 0;
  localparam int M_ACQ  = 1;
  localparam int M_LOCK = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clk_in;
  logic [PW-1:0] exp_period;
  logic          clr_err;
  logic          rise_pulse, fall_pulse, period_valid, locked, err;
  logic [PW-1:0] period;
  logic [EW-1:0] err_cnt;

  clock_div_checker #(.PERIOD_W(PW), .LOCK_COUNT(LC), .ERR_W(EW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clk_in       (clk_in),
    .exp_period   (exp_period),
    .clr_err      (clr_err),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .err          (err),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint t;
    bit     rise, fall, pv, er, lck;
    int     per, ecnt;
  } ev_t;

  ev_t q[$];
  int  nvec = 0;
  int  nerr = 0;

  // Reference model. Works per clk cycle index since reset release:
  // a rise is seen one cycle after clk_in was first sampled high, the
  // measured period is the distance between rise cycles (capped at CMAX),
  // and loss of clock is CMAX idle cycles counted from the last rise.
  int  cp, last_rise, mst, mcnt, m_period, ec;
  bit  r_prev, p1, p2, m_err, m_pv, m_lck;

  task automatic model_reset();
    cp = 0; last_rise = -1; mst = M_IDLE; mcnt = 0; m_period = 0; ec = 0;
    r_prev = 0; p1 = 0; p2 = 0; m_err = 0; m_pv = 0; m_lck = 0;
    q.delete();
  endtask

  task automatic model_step();
    int meas;
    bit r, f, pv, er;
    pv = 0; er = 0;
    if (clr_err)                ec = 0;
    else if (m_err && ec < EMAX) ec = ec + 1;
    if (r_prev) begin
      meas = cp - last_rise;
      if (meas > CMAX) meas = CMAX;
      last_rise = cp;
      if (mst == M_IDLE) begin
        mst = M_ACQ; mcnt = 0;
      end else begin
        pv = 1; m_period = meas;
        if (mst == M_ACQ) begin
          if (meas == int'(exp_period)) begin
            mcnt = mcnt + 1;
            if (mcnt == LC) mst = M_LOCK;
          end else mcnt = 0;
        end else if (meas != int'(exp_period)) begin
          er = 1; mst = M_ACQ; mcnt = 0;
        end
      end
    end else if (mst != M_IDLE && (cp - last_rise - 1) >= CMAX) begin
      er = 1; mst = M_IDLE;
    end
    m_err = er; m_pv = pv; m_lck = (mst == M_LOCK);
    r = p1 && !p2;
    f = !p1 && p2;
    p2 = p1; p1 = clk_in;
    r_prev = r;
    cp = cp + 1;
    if (r || f || pv || er)
      q.push_back('{t: $time, rise: r, fall: f, pv: pv, er: er, lck: m_lck, per: m_period, ecnt: ec});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_step();
    end
  end

  // Monitor: pops an expected event whenever the DUT shows any output activity
  initial begin
    ev_t e;
    bit  ok;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (rise_pulse || fall_pulse || period_valid || err) begin
          nvec++;
          if (q.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_output t=%0t got r%0b f%0b pv%0b err%0b per=%0d, required no activity",
                     $time, rise_pulse, fall_pulse, period_valid, err, period);
          end else begin
            e = q.pop_front();
            ok = (e.t == $time - 5) && (e.rise == rise_pulse) && (e.fall == fall_pulse) &&
                 (e.pv == period_valid) && (e.er == err) && (e.lck == locked) &&
                 (e.per == int'(period)) && (e.ecnt == int'(err_cnt));
            if (!ok) begin
              nerr++;
              $display("FAIL event t=%0t got r%0b f%0b pv%0b err%0b lck%0b per=%0d ecnt=%0d, required (cycle t=%0t) r%0b f%0b pv%0b err%0b lck%0b per=%0d ecnt=%0d",
                       $time, rise_pulse, fall_pulse, period_valid, err, locked, period, err_cnt,
                       e.t + 5, e.rise, e.fall, e.pv, e.er, e.lck, e.per, e.ecnt);
            end
          end
        end else if (q.size() > 0 && q[0].t <= $time - 5) begin
          e = q.pop_front();
          nvec++; nerr++;
          $display("FAIL missing_event t=%0t got no activity, required r%0b f%0b pv%0b err%0b per=%0d",
                   $time, e.rise, e.fall, e.pv, e.er, e.per);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    nvec++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s: got %0d, required %0d", nm, act, expv);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rise"}, int'(rise_pulse), 0);
    chk({nm, "_fall"}, int'(fall_pulse), 0);
    chk({nm, "_period"}, int'(period), 0);
    chk({nm, "_pv"}, int'(period_valid), 0);
    chk({nm, "_locked"}, int'(locked), 0);
    chk({nm, "_err"}, int'(err), 0);
    chk({nm, "_errcnt"}, int'(err_cnt), 0);
  endtask

  task automatic drive(input bit v);
    @(negedge clk);
    clk_in = v;
  endtask

  task automatic run(input int hi, input int lo, input int n);
    repeat (n) begin
      repeat (hi) drive(1'b1);
      repeat (lo) drive(1'b0);
    end
  endtask

  initial begin
    bit hit;
    int p, hi;
    reset_n = 1'b0; clk_in = 1'b0; clr_err = 1'b0; exp_period = 8'd2;
    #1 chk_zero("por");
    #21 reset_n = 1'b1;

    // clk/2 divider
    run(1, 1, 20);
    chk("lock_div2", int'(locked), 1);
    chk("period_div2", int'(period), 2);

    // 16-cycle clock, 8 high / 8 low
    exp_period = 8'd16;
    run(8, 8, 8);
    chk("lock_16", int'(locked), 1);
    chk("period_16", int'(period), 16);

    // expected period moves while locked, then returns
    exp_period = 8'd15;
    run(8, 8, 1);
    chk("unlock_15", int'(locked), 0);
    exp_period = 8'd16;
    run(8, 8, 7);
    chk("relock_16", int'(locked), 1);

    // loss of clock, then restart
    run(0, 300, 1);
    chk("timeout_unlock", int'(locked), 0);
    run(8, 8, 8);
    chk("relock_after_timeout", int'(locked), 1);

    // short reset mid-lock
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk_zero("midreset");
    #11 reset_n = 1'b1;
    run(8, 8, 8);
    chk("lock_after_reset", int'(locked), 1);

    // 256-cycle period: rise lands on the saturated-counter cycle
    exp_period = 8'd255;
    run(128, 128, 7);
    chk("lock_sat_period", int'(locked), 1);
    chk("period_sat", int'(period), 255);

    // randomized periods, duty cycles and expected values
    repeat (25) begin
      p  = int'($urandom_range(2, 40));
      hi = int'($urandom_range(1, p - 1));
      exp_period = ($urandom_range(0, 3) == 0) ? 8'(p + int'($urandom_range(1, 3))) : 8'(p);
      run(hi, p - hi, int'($urandom_range(3, 8)));
    end

    // drive err_cnt into saturation
    repeat (300) begin
      exp_period = 8'd2;
      run(1, 1, 6);
      exp_period = 8'd3;
      run(1, 1, 3);
    end
    chk("errcnt_sat", int'(err_cnt), EMAX);

    // clear coincident with an err pulse
    exp_period = 8'd2;
    run(1, 1, 6);
    exp_period = 8'd3;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      clk_in = ~clk_in;
      if (m_err) begin
        clr_err = 1'b1;
        hit = 1;
      end
    end
    chk("clr_window_found", int'(hit), 1);
    @(negedge clk);
    clr_err = 1'b0;
    chk("errcnt_clr_wins", int'(err_cnt), 0);

    repeat (6) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
